// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Two-requester round-robin arbiter for one 256-bit line memory
//               port, one transaction outstanding. Optional WAIT timeout is
//               enabled by defining MEM_ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic         clk,
    input  logic         rst_n,

    input  logic         p0_req_valid,
    input  logic         p0_req_rw,
    input  logic [14:0]  p0_req_addr,
    input  logic [255:0] p0_req_wdata,
    output logic         p0_req_ready,
    output logic         p0_resp_valid,
    output logic [255:0] p0_resp_rdata,

    input  logic         p1_req_valid,
    input  logic         p1_req_rw,
    input  logic [14:0]  p1_req_addr,
    input  logic [255:0] p1_req_wdata,
    output logic         p1_req_ready,
    output logic         p1_resp_valid,
    output logic [255:0] p1_resp_rdata,

    output logic         mem_req_valid,
    output logic         mem_req_rw,
    output logic [14:0]  mem_req_addr,
    output logic [255:0] mem_req_wdata,
    input  logic         mem_resp_valid,
    input  logic [255:0] mem_resp_rdata,

    output logic         timeout_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t         r_state;
    logic           r_owner;
    logic           r_last_grant;
    logic           r_rw;
    logic [14:0]    r_addr;
    logic [255:0]   r_wdata;
    logic           r_mem_req_valid;
    logic           r_p0_ready;
    logic           r_p1_ready;

    logic           w_req_any;
    logic           w_grant_sel;
    logic           w_sel_rw;
    logic [14:0]    w_sel_addr;
    logic [255:0]   w_sel_wdata;
    logic           w_complete;
    logic           w_timeout;
    logic           w_finish;
    logic [255:0]   w_resp_data;

    // On a tie the requester that did not win last time takes the port.
    always_comb begin
        w_req_any   = p0_req_valid | p1_req_valid;
        w_grant_sel = (p0_req_valid && p1_req_valid) ? ~r_last_grant : p1_req_valid;
        w_sel_rw    = w_grant_sel ? p1_req_rw    : p0_req_rw;
        w_sel_addr  = w_grant_sel ? p1_req_addr  : p0_req_addr;
        w_sel_wdata = w_grant_sel ? p1_req_wdata : p0_req_wdata;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state         <= S_IDLE;
            r_owner         <= 1'b0;
            r_last_grant    <= 1'b1;
            r_rw            <= 1'b0;
            r_addr          <= '0;
            r_wdata         <= '0;
            r_mem_req_valid <= 1'b0;
            r_p0_ready      <= 1'b0;
            r_p1_ready      <= 1'b0;
        end else begin
            r_mem_req_valid <= 1'b0;
            r_p0_ready      <= 1'b0;
            r_p1_ready      <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_req_any) begin
                        r_owner         <= w_grant_sel;
                        r_last_grant    <= w_grant_sel;
                        r_rw            <= w_sel_rw;
                        r_addr          <= w_sel_addr;
                        r_wdata         <= w_sel_wdata;
                        r_mem_req_valid <= 1'b1;
                        r_p0_ready      <= ~w_grant_sel;
                        r_p1_ready      <= w_grant_sel;
                        r_state         <= S_ISSUE;
                    end
                end
                S_ISSUE: r_state <= S_WAIT;
                S_WAIT: begin
                    if (w_finish) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign w_complete = (r_state == S_WAIT) && mem_resp_valid;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam logic [15:0] C_TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] r_wait_cnt;
    logic        r_timeout_err;

    // The counter reads N-1 during WAIT cycle N; a response in that cycle wins.
    assign w_timeout = (r_state == S_WAIT) && !mem_resp_valid && (r_wait_cnt == C_TIMEOUT_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wait_cnt    <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (r_state == S_IDLE && w_req_any) begin
                r_wait_cnt <= '0;
            end else if (r_state == S_WAIT) begin
                r_wait_cnt <= r_wait_cnt + 16'd1;
            end
            if (w_timeout) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    assign timeout_err = r_timeout_err;
`else
    logic [31:0] w_unused_timeout_cycles;
    assign w_unused_timeout_cycles = 32'(TIMEOUT_CYCLES);
    assign w_timeout   = 1'b0;
    assign timeout_err = 1'b0;
`endif

    assign w_finish    = w_complete | w_timeout;
    assign w_resp_data = w_complete ? mem_resp_rdata : '0;

    assign mem_req_valid = r_mem_req_valid;
    assign mem_req_rw    = r_rw;
    assign mem_req_addr  = r_addr;
    assign mem_req_wdata = r_wdata;

    assign p0_req_ready  = r_p0_ready;
    assign p1_req_ready  = r_p1_ready;
    assign p0_resp_valid = w_finish & ~r_owner;
    assign p1_resp_valid = w_finish & r_owner;
    assign p0_resp_rdata = p0_resp_valid ? w_resp_data : '0;
    assign p1_resp_rdata = p1_resp_valid ? w_resp_data : '0;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Randomised and directed bench for mem_port_arbiter against a
//               transaction-timing reference model and a line memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int TMO = 64;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         p0_req_valid = 1'b0, p0_req_rw = 1'b0;
    logic [14:0]  p0_req_addr = '0;
    logic [255:0] p0_req_wdata = '0;
    logic         p0_req_ready, p0_resp_valid;
    logic [255:0] p0_resp_rdata;
    logic         p1_req_valid = 1'b0, p1_req_rw = 1'b0;
    logic [14:0]  p1_req_addr = '0;
    logic [255:0] p1_req_wdata = '0;
    logic         p1_req_ready, p1_resp_valid;
    logic [255:0] p1_resp_rdata;
    logic         mem_req_valid, mem_req_rw;
    logic [14:0]  mem_req_addr;
    logic [255:0] mem_req_wdata;
    logic         mem_resp_valid = 1'b0;
    logic [255:0] mem_resp_rdata = '0;
    logic         timeout_err;

    mem_port_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req_valid(p0_req_valid), .p0_req_rw(p0_req_rw), .p0_req_addr(p0_req_addr),
        .p0_req_wdata(p0_req_wdata), .p0_req_ready(p0_req_ready),
        .p0_resp_valid(p0_resp_valid), .p0_resp_rdata(p0_resp_rdata),
        .p1_req_valid(p1_req_valid), .p1_req_rw(p1_req_rw), .p1_req_addr(p1_req_addr),
        .p1_req_wdata(p1_req_wdata), .p1_req_ready(p1_req_ready),
        .p1_resp_valid(p1_resp_valid), .p1_resp_rdata(p1_resp_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw), .mem_req_addr(mem_req_addr),
        .mem_req_wdata(mem_req_wdata), .mem_resp_valid(mem_resp_valid),
        .mem_resp_rdata(mem_resp_rdata), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    task automatic check_value(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    // Requester drivers: 0 = directed, 1 = random traffic, 2 = sustained contention
    int           mode = 0;
    int           left [2];
    bit           rv [2];
    bit           rrw [2];
    logic [14:0]  raddr [2];
    logic [255:0] rwd [2];
    bit           rst_req = 1'b1;

    // Memory model
    logic [255:0] mem_wr [logic [14:0]];
    bit           mpend = 0, mrw = 0, mute = 0, spur_en = 0;
    int           mresp_cyc = 0, mlat = 50;
    logic [14:0]  maddr = '0;

    // Reference model: transaction timing derived from the arbitration rules
    bit           m_busy = 0, m_owner = 0, m_last = 1, m_terr = 0, m_rw = 0;
    int           m_issue = 0, m_arb_ok = 0;
    logic [14:0]  m_addr = '0;
    logic [255:0] m_wd = '0;

    // Observation records
    logic [255:0] got_rdata [2];
    int           resp_cyc [2];
    int           issue_cyc [2];
    int           resp_cnt [2];
    bit           issue_q [$];

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [255:0] line_of(input logic [14:0] a);
        logic [15:0] a16;
        if (mem_wr.exists(a)) return mem_wr[a];
        a16 = {1'b0, a};
        return {16{a16}};
    endfunction

    task automatic set_req(input int p, input bit rw, input logic [14:0] a, input logic [255:0] wd);
        rv[p] = 1'b1; rrw[p] = rw; raddr[p] = a; rwd[p] = wd;
    endtask

    task automatic new_rand_req(input int p);
        set_req(p, 1'($urandom_range(0, 1)), 15'($urandom_range(0, 7)), rand256());
    endtask

    task automatic step();
        logic         mrv;
        logic [255:0] mrd;
        bit           e_iss, e_rsp, e_tmo, own, seen;
        logic [255:0] e_data;
        @(negedge clk);
        mrv = 1'b0;
        mrd = rand256();
        if (mpend && cyc == mresp_cyc) begin
            mrv   = 1'b1;
            mpend = 1'b0;
            if (!mrw) mrd = line_of(maddr);
        end else if (spur_en && !mpend && (!m_busy || cyc == m_issue) && $urandom_range(0, 15) == 0) begin
            mrv = 1'b1;
        end
        rst_n          = rst_req;
        mem_resp_valid = mrv;
        mem_resp_rdata = mrd;
        p0_req_valid = rv[0]; p0_req_rw = rrw[0]; p0_req_addr = raddr[0]; p0_req_wdata = rwd[0];
        p1_req_valid = rv[1]; p1_req_rw = rrw[1]; p1_req_addr = raddr[1]; p1_req_wdata = rwd[1];
        #1;
        e_iss = m_busy && cyc == m_issue;
        check_value("mem_req_valid", 256'(mem_req_valid), 256'(e_iss));
        check_value("p0_req_ready", 256'(p0_req_ready), 256'(e_iss && !m_owner));
        check_value("p1_req_ready", 256'(p1_req_ready), 256'(e_iss && m_owner));
        check_value("mem_req_rw", 256'(mem_req_rw), 256'(m_rw));
        check_value("mem_req_addr", 256'(mem_req_addr), 256'(m_addr));
        check_value("mem_req_wdata", mem_req_wdata, m_wd);
        e_rsp = 0; e_tmo = 0; e_data = '0;
        if (m_busy && cyc > m_issue) begin
            if (mrv) begin
                e_rsp = 1; e_data = mrd;
            end
`ifdef MEM_ARB_TIMEOUT_EN
            else if (cyc - m_issue == TMO) begin
                e_rsp = 1; e_tmo = 1;
            end
`endif
        end
        check_value("p0_resp_valid", 256'(p0_resp_valid), 256'(e_rsp && !m_owner));
        check_value("p1_resp_valid", 256'(p1_resp_valid), 256'(e_rsp && m_owner));
        check_value("p0_resp_rdata", p0_resp_rdata, (e_rsp && !m_owner) ? e_data : 256'd0);
        check_value("p1_resp_rdata", p1_resp_rdata, (e_rsp && m_owner) ? e_data : 256'd0);
        check_value("timeout_err", 256'(timeout_err), 256'(m_terr));

        if (p0_resp_valid) begin got_rdata[0] = p0_resp_rdata; resp_cyc[0] = cyc; resp_cnt[0]++; end
        if (p1_resp_valid) begin got_rdata[1] = p1_resp_rdata; resp_cyc[1] = cyc; resp_cnt[1]++; end
        if (mem_req_valid) begin
            own = p1_req_ready;
            issue_q.push_back(own);
            issue_cyc[own] = cyc;
            maddr = mem_req_addr;
            mrw   = mem_req_rw;
            if (mem_req_rw) mem_wr[mem_req_addr] = mem_req_wdata;
            if (!mute) begin
                mpend     = 1'b1;
                mresp_cyc = cyc + ((mlat == 0) ? $urandom_range(1, 12) : mlat);
            end
        end

        if (!rst_req) begin
            m_busy = 0; m_owner = 0; m_last = 1; m_terr = 0; m_arb_ok = cyc + 1;
            m_rw = 0; m_addr = '0; m_wd = '0;
        end else if (e_rsp) begin
            m_busy   = 0;
            m_arb_ok = cyc + 2;
            if (e_tmo) m_terr = 1;
        end else if (!m_busy && cyc >= m_arb_ok && (rv[0] || rv[1])) begin
            m_owner = (rv[0] && rv[1]) ? !m_last : rv[1];
            m_last  = m_owner;
            m_rw    = rrw[m_owner]; m_addr = raddr[m_owner]; m_wd = rwd[m_owner];
            m_busy  = 1;
            m_issue = cyc + 1;
        end

        for (int p = 0; p < 2; p++) begin
            seen = (p == 0) ? p0_resp_valid : p1_resp_valid;
            if (rv[p] && seen) begin
                if (mode == 1 && $urandom_range(0, 1) == 1) new_rand_req(p);
                else if (mode == 2 && left[p] > 0) begin left[p]--; new_rand_req(p); end
                else rv[p] = 1'b0;
            end else if (!rv[p] && mode == 1 && $urandom_range(0, 3) == 0) begin
                new_rand_req(p);
            end
        end
        cyc++;
    endtask

    task automatic drain(input string tag, input int budget);
        int k = 0;
        while ((rv[0] || rv[1] || m_busy || mpend) && k < budget) begin
            step();
            k++;
        end
        check_value(tag, 256'(rv[0] || rv[1] || m_busy || mpend), 256'd0);
        step();
        step();
    endtask

    initial begin
        bit ok;
        int k;
        int base0;
        for (int p = 0; p < 2; p++) begin
            rv[p] = 0; rrw[p] = 0; raddr[p] = '0; rwd[p] = '0;
            resp_cnt[p] = 0; resp_cyc[p] = 0; issue_cyc[p] = 0; got_rdata[p] = '0; left[p] = 0;
        end
        repeat (3) @(posedge clk);
        rst_n = 1'b1;

        // Reset state, then a tie straight after reset goes to p0
        step();
        set_req(0, 0, 15'h0011, '0);
        set_req(1, 0, 15'h0022, '0);
        drain("tie_bound", 400);
        check_value("tie_first", 256'(issue_q[0]), 256'd0);
        check_value("tie_second", 256'(issue_q[1]), 256'd1);
        check_value("tie_gap", 256'(issue_cyc[1] - resp_cyc[0]), 256'd3);
        check_value("tie_p1_data", got_rdata[1], {16{16'h0022}});

        // Sustained contention: four transactions each, strictly alternating
        issue_q.delete();
        mode = 2; left[0] = 3; left[1] = 3; mlat = 0;
        new_rand_req(0);
        new_rand_req(1);
        drain("cont_bound", 800);
        mode = 0;
        check_value("cont_count", 256'(issue_q.size()), 256'd8);
        foreach (issue_q[i]) check_value("cont_order", 256'(issue_q[i]), 256'(i % 2));

        // Single read
        mlat = 50;
        set_req(0, 0, 15'h0010, '0);
        drain("rd_bound", 200);
        check_value("rd_data", got_rdata[0], {16{16'h0010}});

        // Write from p1, read back by p0
        base0 = resp_cnt[0];
        set_req(1, 1, 15'h1234, {32{8'hA5}});
        drain("wr_bound", 200);
        check_value("wr_no_p0_ack", 256'(resp_cnt[0]), 256'(base0));
        set_req(0, 0, 15'h1234, '0);
        drain("rb_bound", 200);
        check_value("rb_data", got_rdata[0], {32{8'hA5}});

        // Reset in the middle of p0's WAIT; the late memory pulse must be dropped
        base0 = resp_cnt[0];
        set_req(0, 0, 15'h0005, '0);
        k = 0;
        while (!(m_busy && cyc > m_issue + 5) && k < 50) begin step(); k++; end
        check_value("rst_reach_wait", 256'(m_busy && cyc > m_issue + 5), 256'd1);
        rv[0] = 0;
        rst_req = 1'b0;
        step();
        step();
        rst_req = 1'b1;
        k = 0;
        while (mpend && k < 100) begin step(); k++; end
        check_value("rst_late_pulse", 256'(mpend), 256'd0);
        check_value("rst_no_resp", 256'(resp_cnt[0]), 256'(base0));
        issue_q.delete();
        set_req(0, 0, 15'h0031, '0);
        set_req(1, 0, 15'h0032, '0);
        drain("rst_tie_bound", 400);
        check_value("rst_tie_first", 256'(issue_q[0]), 256'd0);

        // Random traffic with random latency and spurious memory pulses
        mode = 1; mlat = 0; spur_en = 1;
        repeat (1500) step();
        mode = 0;
        drain("rand_bound", 400);
        spur_en = 0;

        // Memory never answers
        mute = 1; mlat = 50;
        base0 = resp_cnt[0];
        set_req(0, 0, 15'h0040, '0);
        repeat (1000) step();
        ok = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
        ok = 1'b1;
`endif
        check_value("tmo_err", 256'(timeout_err), 256'(ok));
        check_value("tmo_resp_cnt", 256'(resp_cnt[0] - base0), 256'(ok));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
